// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin between requesters A and B, plus an
// optional full-framebuffer clear sequencer compiled in with `define FB_ARB_CLEAR_EN.
module fb_write_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              fb_stall,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_din
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_waddr_q, fb_waddr_d;
  logic [DATA_W-1:0] fb_din_q, fb_din_d;
  logic              last_b_q, last_b_d;
  logic              arb_en;
  logic              grant_a, grant_b;

`ifdef FB_ARB_CLEAR_EN
  typedef enum logic {ST_ARB, ST_CLEAR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] clr_val_q, clr_val_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign arb_en   = !rst && !fb_stall && (state_q == ST_ARB) && !clr_start;
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_value, LAST_ADDR};
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign arb_en     = !rst && !fb_stall;
`endif

  // On a tie the requester that did not win most recently gets the port.
  assign grant_a = arb_en && a_valid && (!b_valid || last_b_q);
  assign grant_b = arb_en && b_valid && (!a_valid || !last_b_q);
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign fb_we    = fb_we_q;
  assign fb_waddr = fb_waddr_q;
  assign fb_din   = fb_din_q;

  always_comb begin
    fb_we_d    = 1'b0;
    fb_waddr_d = fb_waddr_q;
    fb_din_d   = fb_din_q;
    last_b_d   = last_b_q;
    if (grant_a) begin
      fb_we_d    = 1'b1;
      fb_waddr_d = a_addr;
      fb_din_d   = a_data;
      last_b_d   = 1'b0;
    end else if (grant_b) begin
      fb_we_d    = 1'b1;
      fb_waddr_d = b_addr;
      fb_din_d   = b_data;
      last_b_d   = 1'b1;
    end
`ifdef FB_ARB_CLEAR_EN
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_val_d  = clr_val_q;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          cnt_d      = '0;
          clr_val_d  = clr_value;
          clr_busy_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        // A stalled cycle neither writes nor advances the sweep.
        if (!fb_stall) begin
          fb_we_d    = 1'b1;
          fb_waddr_d = cnt_q;
          fb_din_d   = clr_val_q;
          if (cnt_q == LAST_ADDR) begin
            state_d    = ST_ARB;
            cnt_d      = '0;
            clr_busy_d = 1'b0;
            clr_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we_q    <= 1'b0;
      fb_waddr_q <= '0;
      fb_din_q   <= '0;
      last_b_q   <= 1'b1;
`ifdef FB_ARB_CLEAR_EN
      state_q    <= ST_ARB;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
`endif
    end else begin
      fb_we_q    <= fb_we_d;
      fb_waddr_q <= fb_waddr_d;
      fb_din_q   <= fb_din_d;
      last_b_q   <= last_b_d;
`ifdef FB_ARB_CLEAR_EN
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
`endif
    end
  end

`ifdef FB_ARB_CLEAR_EN
  always_ff @(posedge clk) begin
    clr_val_q <= clr_val_d;
  end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter: directed scenarios plus randomized traffic checked
// against a rule-level reference model. Clear scenarios run when FB_ARB_CLEAR_EN is defined.
module tb_fb_write_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              clr_start;
  logic [DATA_W-1:0] clr_value;
  logic              clr_busy, clr_done;
  logic              fb_stall;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_waddr;
  logic [DATA_W-1:0] fb_din;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: who won most recently and what the write port should show.
  bit                exp_last_b;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_din;

  always #5 clk = ~clk;

  fb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .fb_stall(fb_stall),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_din(fb_din)
  );

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0; fb_stall = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last_b = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; fb_stall = 1'b0;
    clr_start = 1'b0; clr_value = 4'h0;
    a_addr = 12'h111; a_data = 4'h1; b_addr = 12'h222; b_data = 4'h2;
    #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready_comb got=%b want=00", {a_ready, b_ready});
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({fb_we, fb_waddr, fb_din, clr_busy, clr_done, a_ready, b_ready} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d we=%b addr=%h din=%h busy=%b done=%b ar=%b br=%b want all 0",
                 i, fb_we, fb_waddr, fb_din, clr_busy, clr_done, a_ready, b_ready);
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b10) begin
      miscompares++; $display("FAIL reset_first_tie got=%b want=10", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({fb_we, fb_waddr, fb_din} !== {1'b1, 12'h111, 4'h1}) begin
      miscompares++;
      $display("FAIL reset_first_write got we=%b addr=%h din=%h want 1/111/1", fb_we, fb_waddr, fb_din);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    a_valid = 1'b1; a_addr = 12'h010; a_data = 4'h3;
    b_valid = 1'b1; b_addr = 12'h020; b_data = 4'hC;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++; $display("FAIL rr_grant cyc=%0d got=%b want=%s", i, {a_ready, b_ready},
                                (i % 2 == 0) ? "10" : "01");
      end
      @(posedge clk); #1;
      vectors++;
      if ((i % 2 == 0) ? ({fb_we, fb_waddr, fb_din} !== {1'b1, 12'h010, 4'h3})
                       : ({fb_we, fb_waddr, fb_din} !== {1'b1, 12'h020, 4'hC})) begin
        miscompares++;
        $display("FAIL rr_write cyc=%0d got we=%b addr=%h din=%h", i, fb_we, fb_waddr, fb_din);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_stall();
    a_valid = 1'b1; a_addr = 12'hFFF; a_data = 4'hA; fb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (a_ready !== 1'b0) begin
        miscompares++; $display("FAIL stall_ready cyc=%0d got=%b want=0", i, a_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (fb_we !== 1'b0) begin
        miscompares++; $display("FAIL stall_we cyc=%0d got=%b want=0", i, fb_we);
      end
    end
    fb_stall = 1'b0;
    #1;
    vectors++;
    if (a_ready !== 1'b1) begin
      miscompares++; $display("FAIL stall_release_ready got=%b want=1", a_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if ({fb_we, fb_waddr, fb_din} !== {1'b1, 12'hFFF, 4'hA}) begin
      miscompares++;
      $display("FAIL stall_write got we=%b addr=%h din=%h want 1/fff/a", fb_we, fb_waddr, fb_din);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_random();
    bit exp_ga, exp_gb;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!a_valid) begin
        a_valid = 1'($urandom_range(0, 1)); a_addr = 12'($urandom); a_data = 4'($urandom);
      end
      if (!b_valid) begin
        b_valid = 1'($urandom_range(0, 1)); b_addr = 12'($urandom); b_data = 4'($urandom);
      end
      fb_stall = ($urandom_range(0, 3) == 0);
`ifndef FB_ARB_CLEAR_EN
      clr_start = 1'($urandom_range(0, 1)); clr_value = 4'($urandom);
`endif
      #1;
      exp_ga = 1'b0; exp_gb = 1'b0;
      if (!fb_stall) begin
        if (a_valid && b_valid) begin
          if (exp_last_b) exp_ga = 1'b1; else exp_gb = 1'b1;
        end else begin
          exp_ga = a_valid; exp_gb = b_valid;
        end
      end
      vectors++;
      if ({a_ready, b_ready} !== {exp_ga, exp_gb}) begin
        miscompares++;
        $display("FAIL rand_grant cyc=%0d got=%b want=%b%b", c, {a_ready, b_ready}, exp_ga, exp_gb);
      end
      if (exp_ga) begin
        exp_we = 1'b1; exp_addr = a_addr; exp_din = a_data; exp_last_b = 1'b0;
      end else if (exp_gb) begin
        exp_we = 1'b1; exp_addr = b_addr; exp_din = b_data; exp_last_b = 1'b1;
      end else begin
        exp_we = 1'b0;
      end
      @(posedge clk); #1;
      vectors++;
      if ({fb_we, fb_waddr, fb_din} !== {exp_we, exp_addr, exp_din}) begin
        miscompares++;
        $display("FAIL rand_write cyc=%0d got %b/%h/%h want %b/%h/%h", c,
                 fb_we, fb_waddr, fb_din, exp_we, exp_addr, exp_din);
      end
`ifndef FB_ARB_CLEAR_EN
      vectors++;
      if ({clr_busy, clr_done} !== 2'b00) begin
        miscompares++; $display("FAIL rand_clr_idle cyc=%0d got=%b%b want=00", c, clr_busy, clr_done);
      end
`endif
      if (exp_ga) a_valid = 1'b0;
      if (exp_gb) b_valid = 1'b0;
    end
    a_valid = 1'b0; b_valid = 1'b0; fb_stall = 1'b0; clr_start = 1'b0;
  endtask

`ifdef FB_ARB_CLEAR_EN
  task automatic test_clear(input int n_stalls);
    int busy_cycles = 0, writes = 0, addr_err = 0, data_err = 0, ready_err = 0, done_cnt = 0;
    int stalls_left = n_stalls, cyc = 0;
    logic [ADDR_W-1:0] next_addr = '0;
    bit done_seen = 1'b0;
    a_valid = 1'b1; a_addr = 12'h123; a_data = 4'h7;
    clr_start = 1'b1; clr_value = 4'h5; fb_stall = 1'b0;
    #1;
    vectors++;
    if (a_ready !== 1'b0) begin
      miscompares++; $display("FAIL clr_start_ready got=%b want=0", a_ready);
    end
    @(posedge clk); #1;
    clr_start = 1'b0;
    while (!done_seen && cyc < DEPTH + 1000) begin
      if (clr_busy) begin
        busy_cycles++;
        if (a_ready !== 1'b0) ready_err++;
      end
      if (fb_we) begin
        if (fb_waddr !== next_addr) addr_err++;
        if (fb_din !== 4'h5) data_err++;
        next_addr++; writes++;
      end
      if (clr_done) begin done_cnt++; done_seen = 1'b1; end
      if (!done_seen) begin
        fb_stall = (stalls_left > 0 && cyc % 50 == 7);
        if (fb_stall) stalls_left--;
        @(posedge clk); #1;
        cyc++;
      end
    end
    fb_stall = 1'b0;
    #1;
    vectors++;
    if (busy_cycles !== DEPTH + n_stalls) begin
      miscompares++; $display("FAIL clr_busy_cycles got=%0d want=%0d", busy_cycles, DEPTH + n_stalls);
    end
    vectors++;
    if (writes !== DEPTH) begin
      miscompares++; $display("FAIL clr_write_count got=%0d want=%0d", writes, DEPTH);
    end
    vectors++;
    if (addr_err + data_err !== 0) begin
      miscompares++; $display("FAIL clr_write_set addr_err=%0d data_err=%0d want 0", addr_err, data_err);
    end
    vectors++;
    if (ready_err !== 0) begin
      miscompares++; $display("FAIL clr_ready_blocked got=%0d cycles ready want 0", ready_err);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL clr_done_seen got=%0d want=1", done_cnt);
    end
    vectors++;
    if (a_ready !== 1'b1) begin
      miscompares++; $display("FAIL clr_after_ready got=%b want=1", a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    vectors++;
    if ({fb_we, fb_waddr, fb_din, clr_done, clr_busy} !== {1'b1, 12'h123, 4'h7, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL clr_after_write got we=%b addr=%h din=%h done=%b busy=%b want 1/123/7/0/0",
               fb_we, fb_waddr, fb_din, clr_done, clr_busy);
    end
  endtask

  task automatic test_clear_abort();
    int done_cnt = 0;
    clr_start = 1'b1; clr_value = 4'h9;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    vectors++;
    if (clr_busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_busy_before got=%b want=1", clr_busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (clr_done || clr_busy || fb_we) done_cnt++;
      @(posedge clk); #1;
    end
    vectors++;
    if (done_cnt !== 0) begin
      miscompares++; $display("FAIL abort_idle got=%0d active cycles want 0", done_cnt);
    end
    test_clear(0);
  endtask
`else
  task automatic test_no_clear();
    do_reset();
    a_valid = 1'b1; a_addr = 12'h0AB; a_data = 4'h6;
    b_valid = 1'b1; b_addr = 12'h0CD; b_data = 4'h9;
    clr_start = 1'b1; clr_value = 4'hF;
    #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b10) begin
      miscompares++; $display("FAIL noclr_grant0 got=%b want=10", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    clr_start = 1'b0;
    vectors++;
    if ({fb_we, fb_waddr, fb_din, clr_busy, clr_done} !== {1'b1, 12'h0AB, 4'h6, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL noclr_write0 got we=%b addr=%h din=%h busy=%b done=%b", fb_we, fb_waddr, fb_din,
               clr_busy, clr_done);
    end
    vectors++;
    if ({a_ready, b_ready} !== 2'b01) begin
      miscompares++; $display("FAIL noclr_grant1 got=%b want=01", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({fb_we, fb_waddr, fb_din, clr_busy, clr_done} !== {1'b1, 12'h0CD, 4'h9, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL noclr_write1 got we=%b addr=%h din=%h busy=%b done=%b", fb_we, fb_waddr, fb_din,
               clr_busy, clr_done);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_random();
`ifdef FB_ARB_CLEAR_EN
    test_clear(0);
    test_clear(10);
    test_clear_abort();
`else
    test_no_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single framebuffer write port (we/waddr/din) between two write requesters (A: host/CPU side, B: pattern/animation engine) and a built-in clear sequencer that fills the whole 4096×4-bit framebuffer with a constant. Sits between the requesters and the framebuffer write port, in the same divided clock domain as the LED controller and framebuffer. It does not touch the framebuffer read ports.

## Interface
- `ADDR_W`, 12: framebuffer address width.
- `DATA_W`, 4: framebuffer word width.
- `DEPTH`, 4096: number of words cleared by the clear sequencer; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system (divided) clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  requester A has a write pending.
- `a_ready`  out  1  requester A write accepted this cycle.
- `a_addr`  in  ADDR_W  requester A address.
- `a_data`  in  DATA_W  requester A data.
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as A, for requester B.
- `clr_start`  in  1  request a full clear.
- `clr_value`  in  DATA_W  fill value; sampled with `clr_start`.
- `clr_busy`  out  1  clear in progress.
- `clr_done`  out  1  one-cycle pulse when the clear completes.
- `fb_stall`  in  1  freeze all writes this cycle.
- `fb_we`  out  1  framebuffer write enable (registered).
- `fb_waddr`  out  ADDR_W  framebuffer write address (registered).
- `fb_din`  out  DATA_W  framebuffer write data (registered).

## Operation
- States: ARB and CLEAR. Reset enters ARB.
- Reset values:
  - `fb_we`, `fb_waddr`, `fb_din`, `clr_busy`, `clr_done` = 0.
  - Last-grant pointer = B, so A wins the first tie.
  - Clear counter = 0.
- `a_ready`/`b_ready` are combinational from registered state plus `a_valid`, `b_valid`, `clr_start` and `fb_stall`.
- ARB:
  - If `fb_stall` or `clr_start` is high, both readies are 0.
  - Otherwise, if only one valid is high, that requester's ready is 1.
  - If both valids are high, grant the requester not granted last (round-robin) and update the pointer.
  - At most one ready is high per cycle.
  - A transfer is valid && ready. It registers `fb_we`=1, `fb_waddr`=addr and `fb_din`=data at the next edge.
  - With no transfer, `fb_we`=0 at the next edge; `fb_waddr`/`fb_din` hold.
- `clr_start` high in ARB (regardless of stall):
  - Next edge: state CLEAR, `clr_busy`=1, counter=0, `clr_value` latched.
  - `clr_start` outranks A/B in the same cycle.
- CLEAR:
  - Both readies are 0 and `clr_start` is ignored.
  - Each non-stalled cycle writes (counter, latched value) and increments the counter.
  - A stalled cycle gives `fb_we`=0 at the next edge and the counter holds.
- End of clear: at the edge that issues address DEPTH-1:
  - state returns to ARB, `clr_busy`=0, `clr_done`=1 for exactly one cycle;
  - the counter wraps to 0;
  - requester readies may assert in that same following cycle.
- Requesters must hold addr/data stable while valid and not ready. The arbiter never drops an accepted write.
- Reset mid-clear aborts the clear with no `clr_done`. Words already written are not restored.

## Timing
- Write latency: 1 cycle from the accept edge to the `fb_we` edge. Throughput is 1 write/cycle.
- A clear with no stall:
  - `clr_start` sampled at edge k;
  - `clr_busy` high from edge k to edge k+DEPTH, i.e. DEPTH cycles;
  - `fb_we`=1 with addresses 0..DEPTH-1 at edges k+1..k+DEPTH;
  - `clr_done` high from edge k+DEPTH for one cycle.
- Each stalled cycle delays completion by one cycle.
- All counter arithmetic is ADDR_W bits. DEPTH-1 is compared at full width with no overflow.

## Configuration
- `FB_ARB_CLEAR_EN` defined: clear sequencer and CLEAR state are compiled in, as described above.
- `FB_ARB_CLEAR_EN` undefined:
  - no CLEAR state and no counter;
  - `clr_start` and `clr_value` are ignored and do not gate the readies;
  - `clr_busy` and `clr_done` are tied to 0;
  - the arbiter is pure ARB.

## Test plan
- Reset: assert `rst` 2 cycles with all valids high. All outputs are 0 during reset. First cycle after release, with `a_valid`=`b_valid`=1: `a_ready`=1 and `b_ready`=0.
- Round-robin: A and B both continuously valid for 6 cycles (A addr 0x010, data 0x3; B addr 0x020, data 0xC). Grants are A,B,A,B,A,B. `fb_we`=1 every cycle with alternating addr/data, delayed 1 cycle.
- Stall: single A write to 0xFFF/0xA with `fb_stall` high 3 cycles. `a_ready`=0 for 3 cycles, then accepted; `fb_we`=1 with 0xFFF/0xA one cycle later. A holds its request throughout.
- Clear: `clr_start`=1 with `clr_value`=0x5 and `a_valid` high in the same cycle.
  - `a_ready` stays 0 and `clr_busy` is high for exactly 4096 cycles.
  - `fb_we` covers addresses 0..4095, all data 0x5, in order.
  - One `clr_done` pulse at the end, then A is accepted in the next cycle.
  - Repeat with `fb_stall` pulsed 10 times: 4106 busy cycles, same write set.
- Clear abort: `rst` asserted at clear cycle 100. State returns to ARB, `clr_busy`=0, no `clr_done`. A new clear then restarts from address 0.
- Build without `FB_ARB_CLEAR_EN`: `clr_start` pulse leaves `clr_busy`/`clr_done` at 0 and A/B arbitration is unaffected.
